adc_frame_scheduler: RTL and testbench



---
 rtl/adc_frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_adc_frame_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_scheduler.sv
// Frame scheduler for a left-justified stereo ADC receiver: issues one start per frame,
// captures the finished sample pair into a 2-deep fall-through buffer and flags overruns/timeouts.
module adc_frame_scheduler #(
    parameter int DATA_WIDTH    = 24,
    parameter int FRAME_BCLKS   = 64,
    parameter int TIMEOUT_BCLKS = 2 * DATA_WIDTH + 4
) (
    input  logic                  BCLK,
    input  logic                  RST,
    input  logic                  enable,
    output logic                  rx_start,
    input  logic                  rx_data_ready,
    input  logic [DATA_WIDTH-1:0] rx_left,
    input  logic [DATA_WIDTH-1:0] rx_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic [15:0]           overrun_count,
    output logic                  timeout_err,
    output logic                  busy
);

    // state | meaning
    // IDLE  | no frame running; waits for enable
    // START | rx_start pulse, frame cycle 0
    // WAIT  | conversion in flight; capture on rx_data_ready or give up on timeout
    // GAP   | pad out the remainder of the frame
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_BCLKS - 1);
    localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT_BCLKS - 2);

    state_t                state;
    logic [7:0]            frame_cnt;
    logic [7:0]            tmo_cnt;

    logic [DATA_WIDTH-1:0] mem_left  [2];
    logic [DATA_WIDTH-1:0] mem_right [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  capture;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    always_ff @(posedge BCLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            rx_start    <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            rx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    frame_cnt <= '0;
                    if (enable) begin
                        state    <= S_START;
                        rx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_START: begin
                    frame_cnt <= 8'd1;
                    tmo_cnt   <= TMO_LOAD;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    tmo_cnt   <= tmo_cnt - 8'd1;
                    if (rx_data_ready) begin
                        state <= S_GAP;
                    end else if (tmo_cnt == 8'd0) begin
                        timeout_err <= 1'b1;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    // Re-arm on the last cycle so starts land exactly FRAME_BCLKS apart
                    if (frame_cnt == FRAME_LAST) begin
                        if (enable) begin
                            state    <= S_START;
                            rx_start <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign capture = (state == S_WAIT) && rx_data_ready;
    assign pop     = out_ready && (count != 2'd0);
    // A pop in the same cycle frees the slot the incoming sample needs
    assign push_ok = capture && ((count != 2'd2) || pop);
    assign drop    = capture && (count == 2'd2) && !pop;

    always_ff @(posedge BCLK or posedge RST) begin
        if (RST) begin
            mem_left[0]   <= '0;
            mem_left[1]   <= '0;
            mem_right[0]  <= '0;
            mem_right[1]  <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            overrun_count <= '0;
        end else begin
            if (push_ok) begin
                mem_left[wr_ptr]  <= rx_left;
                mem_right[wr_ptr] <= rx_right;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (drop && (overrun_count != 16'hFFFF)) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_left  = mem_left[rd_ptr];
    assign out_right = mem_right[rd_ptr];

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler: a behavioural ADC receiver model plus
// per-scenario tasks with hand-computed cycle positions and sample values.
module tb_adc_frame_scheduler;

    localparam int DW = 24;

    logic          BCLK = 1'b0;
    logic          RST  = 1'b1;
    logic          enable = 1'b0;
    logic          rx_start;
    logic          rx_data_ready = 1'b0;
    logic [DW-1:0] rx_left  = '0;
    logic [DW-1:0] rx_right = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;
    logic [15:0]   overrun_count;
    logic          timeout_err;
    logic          busy;

    adc_frame_scheduler dut (
        .BCLK          (BCLK),
        .RST           (RST),
        .enable        (enable),
        .rx_start      (rx_start),
        .rx_data_ready (rx_data_ready),
        .rx_left       (rx_left),
        .rx_right      (rx_right),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_left      (out_left),
        .out_right     (out_right),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 BCLK = ~BCLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] l_tbl [8] = '{24'h1A1A01, 24'h2B2B02, 24'h3C3C03, 24'h4D4D04,
                                 24'h5E5E05, 24'h6F6F06, 24'h707007, 24'h818108};
    logic [DW-1:0] r_tbl [8] = '{24'hA10001, 24'hB20002, 24'hC30003, 24'hD40004,
                                 24'hE50005, 24'hF60006, 24'h070007, 24'h180008};

    int rx_lat = 48;
    int rcnt   = 0;
    int fidx   = 0;

    int            start_q [$];
    int            pop_cyc [$];
    logic [DW-1:0] pop_l   [$];
    logic [DW-1:0] pop_r   [$];

    always @(posedge BCLK) cyc <= cyc + 1;

    // Receiver: data_ready rises rx_lat cycles after the start pulse (never if rx_lat == 0)
    always @(negedge BCLK) begin
        if (rx_start) begin
            rcnt          = 0;
            rx_data_ready = 1'b0;
            rx_left       = l_tbl[fidx % 8];
            rx_right      = r_tbl[fidx % 8];
            fidx          = fidx + 1;
        end else begin
            rcnt = rcnt + 1;
            if (rx_lat != 0 && rcnt == rx_lat) rx_data_ready = 1'b1;
        end
    end

    always @(negedge BCLK) begin
        if (rx_start) start_q.push_back(cyc);
        if (out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            pop_l.push_back(out_left);
            pop_r.push_back(out_right);
        end
    end

    task automatic tick();
        @(posedge BCLK);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_start(output int t, output bit ok);
        t  = -1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rx_start) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        RST  = 1'b0;
        fidx = 0;
        start_q.delete();
        pop_cyc.delete();
        pop_l.delete();
        pop_r.delete();
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        tests++;
        if (rx_start !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_fsm: rx_start=%b busy=%b, required 0 0", rx_start, busy);
        end
        tests++;
        if (out_valid !== 1'b0 || out_left !== '0 || out_right !== '0) begin
            fails++;
            $display("FAIL reset_fifo: valid=%b left=%h right=%h, required 0 0 0", out_valid, out_left, out_right);
        end
        tests++;
        if (overrun_count !== 16'd0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: overrun=%0d timeout=%b, required 0 0", overrun_count, timeout_err);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int t0;
        bit ok;
        do_reset();
        rx_lat    = 48;
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_start(t0, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_first_start: no rx_start within 200 cycles");
        end
        run_to(t0 + 130);
        enable = 1'b0;
        run_to(t0 + 200);
        tests++;
        if (start_q.size() != 3 || start_q[0] != t0 || start_q[1] != t0 + 64 || start_q[2] != t0 + 128) begin
            fails++;
            $display("FAIL basic_starts: got %0d starts (%p), required 3 at offsets 0/64/128 from %0d", start_q.size(), start_q, t0);
        end
        tests++;
        if (pop_cyc.size() != 3 || pop_cyc[0] != t0 + 49 || pop_cyc[1] != t0 + 113 || pop_cyc[2] != t0 + 177) begin
            fails++;
            $display("FAIL basic_out_timing: got %p, required offsets 49/113/177 from %0d", pop_cyc, t0);
        end
        tests++;
        if (pop_l.size() != 3 || pop_l[0] !== l_tbl[0] || pop_l[1] !== l_tbl[1] || pop_l[2] !== l_tbl[2]
            || pop_r[2] !== r_tbl[2]) begin
            fails++;
            $display("FAIL basic_out_data: got %p, required %h %h %h", pop_l, l_tbl[0], l_tbl[1], l_tbl[2]);
        end
        tests++;
        if (overrun_count !== 16'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_end: overrun=%0d busy=%b, required 0 0", overrun_count, busy);
        end
    endtask

    task automatic test_overrun();
        int t0;
        bit ok;
        do_reset();
        rx_lat    = 48;
        out_ready = 1'b0;
        enable    = 1'b1;
        wait_start(t0, ok);
        run_to(t0 + 3 * 64 + 10);
        enable = 1'b0;
        run_to(t0 + 4 * 64 + 5);
        tests++;
        if (start_q.size() != 4 || busy !== 1'b0) begin
            fails++;
            $display("FAIL overrun_frames: starts=%0d busy=%b, required 4 0", start_q.size(), busy);
        end
        tests++;
        if (overrun_count !== 16'd2) begin
            fails++;
            $display("FAIL overrun_count: got %0d, required 2", overrun_count);
        end
        tests++;
        if (out_valid !== 1'b1 || out_left !== l_tbl[0] || out_right !== r_tbl[0]) begin
            fails++;
            $display("FAIL overrun_head: valid=%b left=%h right=%h, required 1 %h %h", out_valid, out_left, out_right, l_tbl[0], r_tbl[0]);
        end
        out_ready = 1'b1;
        run_to(cyc + 4);
        tests++;
        if (pop_l.size() != 2 || pop_l[0] !== l_tbl[0] || pop_l[1] !== l_tbl[1] || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL overrun_drain: got %p valid=%b, required %h %h then empty", pop_l, out_valid, l_tbl[0], l_tbl[1]);
        end
    endtask

    task automatic test_full_pop();
        int t0;
        bit ok;
        do_reset();
        rx_lat    = 48;
        out_ready = 1'b0;
        enable    = 1'b1;
        wait_start(t0, ok);
        run_to(t0 + 130);
        enable = 1'b0;
        run_to(t0 + 176);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_to(t0 + 200);
        tests++;
        if (overrun_count !== 16'd0) begin
            fails++;
            $display("FAIL fullpop_overrun: got %0d, required 0", overrun_count);
        end
        tests++;
        if (pop_l.size() != 1 || pop_l[0] !== l_tbl[0] || pop_cyc[0] != t0 + 176) begin
            fails++;
            $display("FAIL fullpop_first: got %p at %p, required %h at %0d", pop_l, pop_cyc, l_tbl[0], t0 + 176);
        end
        tests++;
        if (out_valid !== 1'b1 || out_left !== l_tbl[1]) begin
            fails++;
            $display("FAIL fullpop_head: valid=%b left=%h, required 1 %h", out_valid, out_left, l_tbl[1]);
        end
        out_ready = 1'b1;
        run_to(cyc + 4);
        tests++;
        if (pop_l.size() != 3 || pop_l[1] !== l_tbl[1] || pop_l[2] !== l_tbl[2] || pop_r[2] !== r_tbl[2]) begin
            fails++;
            $display("FAIL fullpop_order: got %p, required %h %h %h", pop_l, l_tbl[0], l_tbl[1], l_tbl[2]);
        end
    endtask

    task automatic test_timeout();
        int t0;
        int t1;
        bit ok;
        do_reset();
        rx_lat    = 0;
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_start(t0, ok);
        run_to(t0 + 51);
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: timeout_err=%b at offset 51, required 0", timeout_err);
        end
        tick();
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_set: timeout_err=%b at offset 52, required 1", timeout_err);
        end
        rx_lat = 48;
        wait_start(t1, ok);
        tests++;
        if (!ok || t1 != t0 + 64) begin
            fails++;
            $display("FAIL timeout_next_start: got cycle %0d, required %0d", t1, t0 + 64);
        end
        enable = 1'b0;
        run_to(t0 + 140);
        tests++;
        if (pop_cyc.size() != 1 || pop_cyc[0] != t0 + 113 || pop_l[0] !== l_tbl[1]) begin
            fails++;
            $display("FAIL timeout_nopush: got pops %p at %p, required one %h at %0d", pop_l, pop_cyc, l_tbl[1], t0 + 113);
        end
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_enable_drop();
        int t0;
        bit ok;
        do_reset();
        rx_lat    = 48;
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_start(t0, ok);
        run_to(t0 + 10);
        enable = 1'b0;
        run_to(t0 + 63);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL endrop_busy63: busy=%b, required 1", busy);
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL endrop_busy64: busy=%b, required 0", busy);
        end
        run_to(t0 + 140);
        tests++;
        if (start_q.size() != 1 || pop_cyc.size() != 1 || pop_cyc[0] != t0 + 49 || pop_l[0] !== l_tbl[0]) begin
            fails++;
            $display("FAIL endrop_frame: starts=%0d pops=%p at %p, required 1 start, %h at %0d", start_q.size(), pop_l, pop_cyc, l_tbl[0], t0 + 49);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok;
        do_reset();
        rx_lat    = 48;
        out_ready = 1'b0;
        enable    = 1'b1;
        wait_start(t0, ok);
        run_to(t0 + 64 + 30);
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: valid=%b busy=%b, required 1 1", out_valid, busy);
        end
        RST = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || overrun_count !== 16'd0 || busy !== 1'b0 || out_left !== '0) begin
            fails++;
            $display("FAIL rstmid_async: valid=%b overrun=%0d busy=%b left=%h, required 0 0 0 0", out_valid, overrun_count, busy, out_left);
        end
        tick();
        RST = 1'b0;
        tests++;
        if (rx_start !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_release: rx_start=%b in release cycle, required 0", rx_start);
        end
        tick();
        tests++;
        if (rx_start !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_restart: rx_start=%b busy=%b, required 1 1", rx_start, busy);
        end
        enable = 1'b0;
        run_to(cyc + 70);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_pop();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
